// File: rtl/motor_command_sequencer_if.sv
// Signal bundle between the motion planner / feedback core / actuator and the sequencer.
interface motor_command_sequencer_if;
    logic [15:0] setpoint;
    logic        setpoint_valid;
    logic        setpoint_ready;
    logic [15:0] motor_command;
    logic [15:0] motor_correction;
    logic        veto_in;
    logic [1:0]  attention_level;
    logic [15:0] act_data;
    logic        act_valid;
    logic        act_ready;
    logic [7:0]  veto_count;

    modport slave (
        input  setpoint, setpoint_valid, motor_correction, veto_in, attention_level, act_ready,
        output setpoint_ready, motor_command, act_data, act_valid, veto_count
    );

    modport master (
        output setpoint, setpoint_valid, motor_correction, veto_in, attention_level, act_ready,
        input  setpoint_ready, motor_command, act_data, act_valid, veto_count
    );
endinterface

// File: rtl/motor_command_sequencer.sv
// Accepts planner setpoints, waits for the feedback core to settle, applies its gain-scaled
// correction with saturation and a slew limit, and offers the result to the actuator.
module motor_command_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] MAX_STEP      = 16'd256,
    parameter int unsigned VETO_HOLD     = 8
) (
    input logic                      clk_100mhz,
    input logic                      rst,
    motor_command_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_APPLY, S_DRIVE, S_VETO_HOLD} state_e;

    localparam logic [7:0]         SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]         HOLD_LOAD   = 8'(VETO_HOLD - 1);
    localparam logic signed [16:0] STEP_POS    = {1'b0, MAX_STEP};
    localparam logic signed [16:0] STEP_NEG    = -STEP_POS;

    state_e      state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] motor_command_q, motor_command_d;
    logic [15:0] act_data_q, act_data_d;
    logic        act_valid_q, act_valid_d;
    logic [15:0] last_out_q, last_out_d;
    logic [7:0]  veto_count_q, veto_count_d;
    logic        veto_prev_q, veto_prev_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        settle_zero_q, settle_zero_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        setpoint_ready_q, setpoint_ready_d;

    logic [1:0]         shift;
    logic signed [15:0] scaled;
    logic signed [16:0] cand_wide;
    logic [15:0]        cand;
    logic signed [16:0] delta_wide;
    logic signed [16:0] delta;
    logic [16:0]        out_wide;
    logic [15:0]        apply_out;

    always_comb begin
        shift     = 2'd3 - bus.attention_level;
        scaled    = $signed(bus.motor_correction) >>> shift;
        cand_wide = {cmd_q[15], cmd_q} + {scaled[15], scaled};
        // Overflow shows as disagreement between the two top bits of the 17-bit sum.
        if (cand_wide[16] != cand_wide[15]) begin
            cand = cand_wide[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            cand = cand_wide[15:0];
        end
        delta_wide = {cand[15], cand} - {last_out_q[15], last_out_q};
        if (delta_wide > STEP_POS) begin
            delta = STEP_POS;
        end else if (delta_wide < STEP_NEG) begin
            delta = STEP_NEG;
        end else begin
            delta = delta_wide;
        end
        out_wide  = {last_out_q[15], last_out_q} + delta;
        apply_out = out_wide[15:0];
    end

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        motor_command_d = motor_command_q;
        act_data_d      = act_data_q;
        act_valid_d     = act_valid_q;
        last_out_d      = last_out_q;
        veto_count_d    = veto_count_q;
        veto_prev_d     = bus.veto_in;
        settle_cnt_d    = settle_cnt_q;
        settle_zero_d   = settle_zero_q;
        hold_cnt_d      = hold_cnt_q;

        if (bus.veto_in && !veto_prev_q && (veto_count_q != 8'hFF)) begin
            veto_count_d = veto_count_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.setpoint_valid) begin
                    cmd_d           = bus.setpoint;
                    motor_command_d = bus.setpoint;
                    settle_cnt_d    = SETTLE_LOAD;
                    settle_zero_d   = 1'b0;
                    state_d         = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The counter first reaches zero, then one more cycle passes before APPLY.
                if (bus.veto_in) begin
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = S_VETO_HOLD;
                end else if (settle_zero_q) begin
                    state_d = S_APPLY;
                end else if (settle_cnt_q == 8'd0) begin
                    settle_zero_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            S_APPLY: begin
                if (bus.veto_in) begin
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = S_VETO_HOLD;
                end else begin
                    act_data_d  = apply_out;
                    act_valid_d = 1'b1;
                    state_d     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (bus.act_ready) begin
                    last_out_d  = act_data_q;
                    act_valid_d = 1'b0;
                    hold_cnt_d  = HOLD_LOAD;
                    state_d     = bus.veto_in ? S_VETO_HOLD : S_IDLE;
                end else if (bus.veto_in) begin
                    act_valid_d = 1'b0;
                    hold_cnt_d  = HOLD_LOAD;
                    state_d     = S_VETO_HOLD;
                end
            end
            S_VETO_HOLD: begin
                if (bus.veto_in) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        setpoint_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cmd_q            <= '0;
            motor_command_q  <= '0;
            act_data_q       <= '0;
            act_valid_q      <= 1'b0;
            last_out_q       <= '0;
            veto_count_q     <= '0;
            veto_prev_q      <= 1'b0;
            settle_cnt_q     <= '0;
            settle_zero_q    <= 1'b0;
            hold_cnt_q       <= '0;
            setpoint_ready_q <= 1'b1;
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            motor_command_q  <= motor_command_d;
            act_data_q       <= act_data_d;
            act_valid_q      <= act_valid_d;
            last_out_q       <= last_out_d;
            veto_count_q     <= veto_count_d;
            veto_prev_q      <= veto_prev_d;
            settle_cnt_q     <= settle_cnt_d;
            settle_zero_q    <= settle_zero_d;
            hold_cnt_q       <= hold_cnt_d;
            setpoint_ready_q <= setpoint_ready_d;
        end
    end

    assign bus.setpoint_ready = setpoint_ready_q;
    assign bus.motor_command  = motor_command_q;
    assign bus.act_data       = act_data_q;
    assign bus.act_valid      = act_valid_q;
    assign bus.veto_count     = veto_count_q;
endmodule

// File: tb/tb_motor_command_sequencer.sv
// Bench for motor_command_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the sequencer.
module tb_motor_command_sequencer;
    localparam int S  = 4;
    localparam int MS = 256;
    localparam int VH = 8;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_OFFER = 2;
    localparam int P_HOLD  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    motor_command_sequencer_if bif ();

    motor_command_sequencer #(
        .SETTLE_CYCLES(S),
        .MAX_STEP     (16'(MS)),
        .VETO_HOLD    (VH)
    ) dut (
        .clk_100mhz(clk),
        .rst       (rst),
        .bus       (bif.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Output value the sequencer must produce from command, correction, gain and previous output.
    function automatic logic [15:0] model_out(input logic [15:0] cmd, input logic [15:0] corr,
                                              input logic [1:0] att, input logic [15:0] last);
        int c, d, q, cand, delta;
        c = int'($signed(corr));
        d = 1 << (3 - int'(att));
        q = c / d;
        if (c < 0 && (c % d) != 0) q = q - 1;
        cand = int'($signed(cmd)) + q;
        if (cand > 32767) cand = 32767;
        if (cand < -32768) cand = -32768;
        delta = cand - int'($signed(last));
        if (delta > MS) delta = MS;
        if (delta < -MS) delta = -MS;
        return 16'(int'($signed(last)) + delta);
    endfunction

    int          m_phase, m_age, m_quiet, m_vcount;
    logic        m_vprev, m_valid;
    logic [15:0] m_cmd, m_mc, m_data, m_last;

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_quiet = 0; m_vcount = 0;
        m_vprev = 1'b0; m_valid = 1'b0;
        m_cmd = '0; m_mc = '0; m_data = '0; m_last = '0;
    endtask

    always @(posedge clk) begin
        logic veto, spv, rdy;
        logic [15:0] sp, corr;
        logic [1:0]  att;
        veto = bif.veto_in; spv = bif.setpoint_valid; rdy = bif.act_ready;
        sp = bif.setpoint; corr = bif.motor_correction; att = bif.attention_level;
        if (rst) begin
            model_reset();
        end else begin
            if (veto && !m_vprev && m_vcount < 255) m_vcount++;
            m_vprev = veto;
            case (m_phase)
                P_IDLE: if (spv) begin
                    m_cmd = sp; m_mc = sp; m_age = 0; m_phase = P_WAIT;
                end
                P_WAIT: begin
                    m_age++;
                    if (veto) begin
                        m_quiet = 0; m_phase = P_HOLD;
                    end else if (m_age == S + 2) begin
                        m_data = model_out(m_cmd, corr, att, m_last);
                        m_valid = 1'b1; m_phase = P_OFFER;
                    end
                end
                P_OFFER: begin
                    if (rdy) begin
                        m_last = m_data; m_valid = 1'b0; m_quiet = 0;
                        m_phase = veto ? P_HOLD : P_IDLE;
                    end else if (veto) begin
                        m_valid = 1'b0; m_quiet = 0; m_phase = P_HOLD;
                    end
                end
                default: begin
                    if (veto) m_quiet = 0;
                    else m_quiet++;
                    if (m_quiet == VH) m_phase = P_IDLE;
                end
            endcase
        end
        #3;
        check("setpoint_ready", 32'(bif.setpoint_ready), 32'(m_phase == P_IDLE));
        check("motor_command", 32'(bif.motor_command), 32'(m_mc));
        check("act_valid", 32'(bif.act_valid), 32'(m_valid));
        check("act_data", 32'(bif.act_data), 32'(m_data));
        check("veto_count", 32'(bif.veto_count), 32'(m_vcount));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [15:0] sp, input logic [15:0] corr, input logic [1:0] att,
                        input int rdy_delay, output int lat, output logic [15:0] data);
        int n;
        n = 0;
        while (!bif.setpoint_ready && n < 50) begin tick(); n++; end
        bif.setpoint = sp; bif.motor_correction = corr; bif.attention_level = att;
        bif.setpoint_valid = 1'b1; bif.act_ready = 1'b0;
        tick();
        bif.setpoint_valid = 1'b0;
        lat = 0;
        while (!bif.act_valid && lat < 50) begin tick(); lat++; end
        data = bif.act_data;
        for (int i = 0; i < rdy_delay; i++) tick();
        bif.act_ready = 1'b1;
        tick();
        bif.act_ready = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check({tag, "_motor_command"}, 32'(bif.motor_command), 32'h0);
        check({tag, "_act_valid"}, 32'(bif.act_valid), 32'h0);
        check({tag, "_act_data"}, 32'(bif.act_data), 32'h0);
        check({tag, "_veto_count"}, 32'(bif.veto_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        logic [15:0] d;
        bif.setpoint = '0; bif.setpoint_valid = 1'b0; bif.motor_correction = '0;
        bif.veto_in = 1'b0; bif.attention_level = '0; bif.act_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_motor_command", 32'(bif.motor_command), 32'h0);
        check("reset_act_valid", 32'(bif.act_valid), 32'h0);
        check("reset_act_data", 32'(bif.act_data), 32'h0);
        check("reset_veto_count", 32'(bif.veto_count), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_ready", 32'(bif.setpoint_ready), 32'h1);

        xfer(16'd1000, 16'd80, 2'd2, 0, lat, d);
        check("latency", 32'(lat), 32'd6);
        check("slew_clamp", 32'(d), 32'd256);
        xfer(16'd300, 16'hFFF0, 2'd3, 2, lat, d);
        check("gain_att3", 32'(d), 32'd284);
        xfer(16'd300, 16'hFFF0, 2'd0, 0, lat, d);
        check("gain_att0", 32'(d), 32'd298);

        // Backpressure then veto while offering.
        bif.setpoint = 16'd5000; bif.motor_correction = '0; bif.attention_level = 2'd3;
        bif.setpoint_valid = 1'b1;
        tick();
        bif.setpoint_valid = 1'b0;
        n = 0;
        while (!bif.act_valid && n < 50) begin tick(); n++; end
        check("bp_data", 32'(bif.act_data), 32'd554);
        for (int i = 0; i < 5; i++) tick();
        check("bp_held", 32'(bif.act_valid), 32'h1);
        bif.veto_in = 1'b1;
        tick();
        bif.veto_in = 1'b0;
        check("veto_drop_valid", 32'(bif.act_valid), 32'h0);
        check("veto_count_1", 32'(bif.veto_count), 32'd1);
        n = 0;
        while (!bif.setpoint_ready && n < 50) begin tick(); n++; end
        check("hold_len", 32'(n), 32'd8);
        xfer(16'd1000, 16'd0, 2'd3, 0, lat, d);
        check("last_out_kept", 32'(d), 32'd554);

        // Repeated vetoes inside the hold window.
        bif.setpoint = 16'd2000; bif.setpoint_valid = 1'b1;
        tick();
        bif.setpoint_valid = 1'b0;
        tick(); tick();
        bif.veto_in = 1'b1;
        tick();
        bif.veto_in = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) tick();
            bif.veto_in = 1'b1;
            tick();
            bif.veto_in = 1'b0;
        end
        n = 0;
        while (!bif.setpoint_ready && n < 50) begin tick(); n++; end
        check("restart_hold_len", 32'(n), 32'd8);
        check("restart_veto_count", 32'(bif.veto_count), 32'd4);

        // Asynchronous reset in SETTLE and in DRIVE.
        bif.setpoint = 16'd3000; bif.setpoint_valid = 1'b1;
        tick();
        bif.setpoint_valid = 1'b0;
        tick();
        async_reset("rst_settle");
        bif.setpoint = 16'd700; bif.setpoint_valid = 1'b1;
        tick();
        bif.setpoint_valid = 1'b0;
        n = 0;
        while (!bif.act_valid && n < 50) begin tick(); n++; end
        check("pre_rst_drive_data", 32'(bif.act_data), 32'd256);
        async_reset("rst_drive");
        tick();
        xfer(16'd100, 16'd0, 2'd3, 0, lat, d);
        check("post_reset_latency", 32'(lat), 32'd6);
        check("post_reset_data", 32'(d), 32'd100);

        // Positive saturation reached by repeated slew-limited steps.
        for (int i = 0; i < 130; i++) xfer(16'h7FF0, 16'h0100, 2'd3, 0, lat, d);
        check("sat_pos", 32'(d), 32'h7FFF);

        // Veto counter saturation.
        for (int i = 0; i < 300; i++) begin
            bif.veto_in = 1'b1; tick();
            bif.veto_in = 1'b0; tick();
        end
        check("veto_sat", 32'(bif.veto_count), 32'd255);
        for (int i = 0; i < 12; i++) tick();

        for (int i = 0; i < 4000; i++) begin
            bif.setpoint_valid   = ($urandom_range(0, 3) == 0);
            bif.setpoint         = 16'($urandom);
            bif.motor_correction = 16'($urandom);
            bif.attention_level  = 2'($urandom_range(0, 3));
            bif.act_ready        = 1'($urandom_range(0, 1));
            bif.veto_in          = ($urandom_range(0, 15) == 0);
            tick();
        end
        bif.setpoint_valid = 1'b0; bif.veto_in = 1'b0; bif.act_ready = 1'b0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
